// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, FSM states and length clamp for the bit-select serializer
package mux_pkg;
    localparam int K = 64;
    localparam int SEL_W = 6;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic logic [SEL_W:0] clamp_len(input logic [SEL_W:0] l);
        return (l == '0 || l > (SEL_W+1)'(K)) ? (SEL_W+1)'(K) : l;
    endfunction
endpackage

// File: rtl/mux_sel_serializer_mux.sv
// mux_sel_serializer_mux: 64:1 bit-select mux
module mux_sel_serializer_mux import mux_pkg::*; (
    input  logic [K-1:0]     data,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);
    assign y = data[sel];
endmodule

// File: rtl/mux_sel_serializer.sv
// mux_sel_serializer: loads a word and walks the mux select LSB-first, one bit per output beat
module mux_sel_serializer import mux_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [K-1:0]     in_data,
    input  logic [SEL_W:0]   in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);
    state_t state, state_d;
    logic [K-1:0] data_q;
    logic [SEL_W:0] len_q;
    logic [SEL_W-1:0] sel_d;
    logic load;
    assign in_ready = state == IDLE;
    assign out_valid = state == SHIFT;
    assign busy = state == SHIFT;
    assign load = in_ready && in_valid && !flush;
    assign out_last = {1'b0, sel} == len_q - 1'b1;
    mux_sel_serializer_mux u_mux (.data(data_q), .sel(sel), .y(out_bit));
    // flush wins over both the load and any beat handshake
    always_comb begin
        state_d = state;
        sel_d = sel;
        if (flush) begin
            state_d = IDLE;
            sel_d = '0;
        end else if (load) begin
            state_d = SHIFT;
            sel_d = '0;
        end else if (out_valid && out_ready) begin
            state_d = out_last ? IDLE : SHIFT;
            sel_d = out_last ? '0 : sel + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel <= '0;
            data_q <= '0;
            len_q <= '0;
        end else begin
            state <= state_d;
            sel <= sel_d;
            if (load) begin
                data_q <= in_data;
                len_q <= clamp_len(in_len);
            end
        end
    end
endmodule

// File: tb/tb_mux_sel_serializer.sv
// tb_mux_sel_serializer: directed scoreboard bench for the bit-select serializer
module tb_mux_sel_serializer;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [63:0] in_data = '0;
    logic [6:0] in_len = '0;
    logic in_ready, out_valid, out_bit, out_last, busy;
    logic [5:0] sel;
    typedef struct packed {logic b; logic l; logic [5:0] s;} exp_t;
    exp_t sb[$];
    int total = 0, passed = 0;

    mux_sel_serializer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .out_valid(out_valid), .out_ready(out_ready),
        .out_bit(out_bit), .out_last(out_last), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_frame(input logic [63:0] d, input logic [6:0] len);
        int n;
        exp_t e;
        n = (len == 0 || len > 64) ? 64 : int'(len);
        for (int i = 0; i < n; i++) begin
            e.b = d[i];
            e.l = (i == n - 1);
            e.s = 6'(i);
            sb.push_back(e);
        end
    endtask

    task automatic load(input logic [63:0] d, input logic [6:0] len);
        @(negedge clk);
        chk("load_in_ready", in_ready, 1);
        in_valid = 1;
        in_data = d;
        in_len = len;
        push_frame(d, len);
        @(posedge clk);
        #1 in_valid = 0;
        in_data = {$urandom, $urandom};
        in_len = 7'($urandom);
    endtask

    task automatic run(input bit bp, input int stop_sel);
        int cyc = 0;
        bit stall = 0;
        logic [5:0] ps;
        logic pb, pl;
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            if (++cyc > 400) begin
                total++;
                $error("FAIL run_timeout observed=%0d pending expected=0", sb.size());
                sb.delete();
                return;
            end
            chk("beat_valid", out_valid, 1);
            chk("beat_busy", busy, 1);
            chk("beat_in_ready", in_ready, 0);
            if (stall) begin
                chk("stall_sel", sel, ps);
                chk("stall_bit", out_bit, pb);
                chk("stall_last", out_last, pl);
            end
            if (stop_sel >= 0 && int'(sel) == stop_sel) return;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = !out_ready;
            ps = sel;
            pb = out_bit;
            pl = out_last;
            if (out_ready) begin
                e = sb.pop_front();
                chk("bit", out_bit, e.b);
                chk("last", out_last, e.l);
                chk("sel", sel, e.s);
            end
        end
        @(negedge clk);
        chk("end_in_ready", in_ready, 1);
        chk("end_out_valid", out_valid, 0);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        exp_t e;
        in_valid = 1'($urandom);
        flush = 1'($urandom);
        out_ready = 1'($urandom);
        in_data = {$urandom, $urandom};
        in_len = 7'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_bit", out_bit, 0);
        rst_n = 1;
        in_valid = 0;
        flush = 0;
        out_ready = 1;

        load(64'hA5A5_0000_FFFF_1234, 7'd0);
        run(0, -1);

        load(64'h13, 7'd5);
        run(0, -1);

        load({$urandom, $urandom}, 7'd8);
        run(1, -1);

        load({$urandom, $urandom}, 7'd1);
        run(0, -1);

        load({$urandom, $urandom}, 7'd100);
        run(0, -1);

        // asynchronous reset in the middle of a frame
        load({$urandom, $urandom}, 7'd0);
        run(0, 17);
        chk("pre_rst_sel", sel, 17);
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_sel", sel, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1;

        // flush mid-frame with a beat handshake pending
        load({$urandom, $urandom}, 7'd0);
        run(0, 30);
        chk("pre_flush_sel", sel, 30);
        flush = 1;
        out_ready = 1;
        @(posedge clk);
        #1 flush = 0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        chk("flush_sel", sel, 0);

        // flush masks a load in IDLE
        flush = 1;
        in_valid = 1;
        in_len = 7'd4;
        @(posedge clk);
        #1 flush = 0;
        in_valid = 0;
        @(negedge clk);
        chk("flush_idle_busy", busy, 0);
        chk("flush_idle_out_valid", out_valid, 0);
        chk("flush_idle_in_ready", in_ready, 1);

        // back-to-back loads with in_valid held: one idle bubble between frames
        in_valid = 1;
        in_data = 64'h5;
        in_len = 7'd3;
        push_frame(64'h5, 7'd3);
        @(posedge clk);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                in_data = 64'h6;
                push_frame(64'h6, 7'd3);
            end
            chk("b2b_out_valid", out_valid, c != 3);
            chk("b2b_in_ready", in_ready, c == 3);
            if (c == 4) in_valid = 0;
            if (c != 3 && sb.size() > 0) begin
                e = sb.pop_front();
                chk("b2b_bit", out_bit, e.b);
                chk("b2b_last", out_last, e.l);
                chk("b2b_sel", sel, e.s);
            end
        end
        @(negedge clk);
        chk("b2b_end_out_valid", out_valid, 0);
        chk("b2b_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
